// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-period helper and frame width.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int DATA_BITS = 8;

    // Rounded to the nearest whole cycle so the baud error stays below half a cycle per bit.
    function automatic int cycles_per_bit(input int clock_hz, input int baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts CPB cycles while running and pulses bit_done on the last one.
module uart_bit_timer #(
    parameter int CPB = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CPB - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_done = !clear && (cnt_q == LAST);
        if (clear || bit_done) cnt_d = '0;
        else                   cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// Stream-to-UART transmitter: one-entry holding register in front of an 8N1/8N2 serialiser,
// so a continuously valid upstream yields back-to-back frames with no idle gap.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ  = 27000000,
    parameter int BAUD_RATE = 115200,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    output logic       ready,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);

    localparam int CPB = cycles_per_bit(CLOCK_HZ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx_stream: cycles per bit must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end

    tx_state_t state_q, state_d;
    logic hold_full_q, hold_full_d;
    logic ready_q, ready_d;
    logic tx_q, tx_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic load;
    logic bit_done;
    logic timer_clear;

    // Timer is held at zero while idle so a new frame always starts on a full start bit.
    assign timer_clear = (state_q == IDLE);

    uart_bit_timer #(.CPB(CPB)) u_bit_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (timer_clear),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        bit_cnt_d   = bit_cnt_q;
        stop_idx_d  = stop_idx_q;
        hold_data_d = hold_data_q;
        shift_d     = shift_q;
        load        = 1'b0;

        if (valid && ready_q) begin
            hold_data_d = data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) load = 1'b1;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_d       = 1'b1;
                        stop_idx_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (stop_idx_q == LAST_STOP) begin
                        if (hold_full_q) load = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer needs a full hold register, a handshake an empty one: never both.
        if (load) begin
            shift_d     = hold_data_q;
            hold_full_d = 1'b0;
            tx_d        = 1'b0;
            state_d     = START;
        end

        ready_d = !hold_full_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            tx_q        <= 1'b1;
            bit_cnt_q   <= '0;
            stop_idx_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            tx_q        <= tx_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_idx_q  <= stop_idx_d;
        end
    end

    always_ff @(posedge clock) begin
        hold_data_q <= hold_data_d;
        shift_q     <= shift_d;
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign busy  = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at CPB=4: reset, single frame, streaming, backpressure,
// reset mid-frame and a two-stop-bit instance.
module tb_uart_tx_stream;

    logic       clock = 1'b0;
    logic       reset, valid, ready, tx, busy;
    logic [7:0] data;
    logic       reset2, valid2, ready2, tx2, busy2;
    logic [7:0] data2;
    int         checks = 0;
    int         passed = 0;

    always #5 clock = ~clock;

    uart_tx_stream #(.CLOCK_HZ(4), .BAUD_RATE(1), .STOP_BITS(1)) dut (
        .clock (clock), .reset (reset), .valid (valid), .ready (ready),
        .data  (data),  .tx    (tx),    .busy  (busy)
    );

    uart_tx_stream #(.CLOCK_HZ(4), .BAUD_RATE(1), .STOP_BITS(2)) dut2 (
        .clock (clock), .reset (reset2), .valid (valid2), .ready (ready2),
        .data  (data2), .tx    (tx2),    .busy  (busy2)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected line level k edges after the handshake edge (1-stop frame: 40 cycles).
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        if (k >= 1 && k <= 4)  return 1'b0;
        if (k >= 5 && k <= 36) return b[3'((k - 5) / 4)];
        return 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; reset2 = 1'b1;
        valid = 1'b1; data = 8'h55;
        valid2 = 1'b0; data2 = 8'h00;
        #1;
        reset = 1'b0; reset2 = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0 || tx !== 1'b1)
                $display("FAIL reset_hold cyc=%0d ready=%b busy=%b tx=%b want 0 0 1", i, ready, busy, tx);
            else passed++;
        end
        reset = 1'b1; reset2 = 1'b1;
        step();
        checks++; if (ready !== 1'b1) $display("FAIL release_ready got %b want 1", ready); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL release_no_capture busy got %b want 0", busy); else passed++;
        checks++; if (ready2 !== 1'b1) $display("FAIL release_ready2 got %b want 1", ready2); else passed++;
        valid = 1'b0;
    endtask

    task automatic test_single();
        data = 8'hA5; valid = 1'b1;
        step();
        valid = 1'b0;
        checks++; if (ready !== 1'b0) $display("FAIL single_ready_hs got %b want 0", ready); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL single_busy_hs got %b want 1", busy); else passed++;
        for (int k = 1; k <= 41; k++) begin
            step();
            checks++;
            if (tx !== exp_tx(8'hA5, k)) $display("FAIL single_tx k=%0d got %b want %b", k, tx, exp_tx(8'hA5, k));
            else passed++;
            checks++;
            if (ready !== 1'b1) $display("FAIL single_ready k=%0d got %b want 1", k, ready); else passed++;
            checks++;
            if (busy !== (k <= 40)) $display("FAIL single_busy k=%0d got %b want %b", k, busy, (k <= 40));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        int idx, hs_n, f;
        logic hs, e;
        seq = '{8'h00, 8'h01, 8'h02};
        idx = 0; hs_n = 0;
        data = seq[0]; valid = 1'b1;
        for (int k = 0; k < 125; k++) begin
            hs = valid && ready;
            step();
            if (hs) begin
                hs_n++;
                if (idx == 2) valid = 1'b0;
                else begin idx++; data = seq[2'(idx)]; end
            end
            if (k >= 1 && k <= 120) begin
                f = (k - 1) / 40;
                e = exp_tx(seq[2'(f)], k - 40 * f);
            end else e = 1'b1;
            checks++;
            if (tx !== e) $display("FAIL b2b_tx k=%0d got %b want %b", k, tx, e); else passed++;
            if (k == 2 || k == 40 || k == 42) begin
                checks++;
                if (ready !== 1'b0) $display("FAIL b2b_ready_held k=%0d got %b want 0", k, ready); else passed++;
            end
            if (k == 41 || k == 81) begin
                checks++;
                if (ready !== 1'b1) $display("FAIL b2b_ready_xfer k=%0d got %b want 1", k, ready); else passed++;
            end
        end
        checks++; if (hs_n !== 3) $display("FAIL b2b_handshakes got %0d want 3", hs_n); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", busy); else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] seq [3];
        int idx, hs_3c, hs_3c_k;
        logic hs, e;
        seq = '{8'h11, 8'h22, 8'h3C};
        idx = 0; hs_3c = 0; hs_3c_k = -1;
        data = seq[0]; valid = 1'b1;
        for (int k = 0; k < 135; k++) begin
            hs = valid && ready;
            step();
            if (hs) begin
                if (data == 8'h3C) begin hs_3c++; hs_3c_k = k; end
                if (idx == 2) valid = 1'b0;
                else begin idx++; data = seq[2'(idx)]; end
            end
            if (k == 20) begin
                checks++;
                if (ready !== 1'b0 || valid !== 1'b1)
                    $display("FAIL bp_stall ready=%b valid=%b want 0 1", ready, valid);
                else passed++;
            end
            if (k >= 81) begin
                e = (k <= 120) ? exp_tx(8'h3C, k - 80) : 1'b1;
                checks++;
                if (tx !== e) $display("FAIL bp_tx k=%0d got %b want %b", k, tx, e); else passed++;
            end
        end
        checks++; if (hs_3c !== 1) $display("FAIL bp_handshakes got %0d want 1", hs_3c); else passed++;
        checks++; if (hs_3c_k !== 42) $display("FAIL bp_hs_edge got %0d want 42", hs_3c_k); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL bp_busy_end got %b want 0", busy); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        data = 8'h50; valid = 1'b1;
        step();
        data = 8'h77;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 2) valid = 1'b0;
        end
        checks++; if (tx !== 1'b0) $display("FAIL mid_bit3 got %b want 0", tx); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy_pre got %b want 1", busy); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) $display("FAIL mid_async_tx got %b want 1", tx); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_async_busy got %b want 0", busy); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL mid_async_ready got %b want 0", ready); else passed++;
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0)
                $display("FAIL mid_after k=%0d tx=%b busy=%b want 1 0", k, tx, busy);
            else passed++;
        end
        checks++; if (ready !== 1'b1) $display("FAIL mid_ready_end got %b want 1", ready); else passed++;
    endtask

    task automatic test_stop2();
        logic e;
        data2 = 8'hFF; valid2 = 1'b1;
        step();
        valid2 = 1'b0;
        for (int k = 1; k <= 46; k++) begin
            step();
            e = (k >= 1 && k <= 4) ? 1'b0 : 1'b1;
            checks++;
            if (tx2 !== e) $display("FAIL stop2_tx k=%0d got %b want %b", k, tx2, e); else passed++;
            if (k == 44 || k == 45) begin
                checks++;
                if (busy2 !== (k == 44)) $display("FAIL stop2_busy k=%0d got %b want %b", k, busy2, (k == 44));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
        test_stop2();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached passed=%0d checks=%0d", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
